// File: rtl/baud_rate_generator.sv
// SPI master serial-clock generator with per-edge sample/shift strobes.
// Latency: sclk and *_edge are registered (1 pclk); BaudRateDivisor and *_pre are combinational.
// Backpressure: none; runs freely while ss is low and the mode allows it, otherwise idles at cpol.
//
// Ports:
//   pclk, preset_n       APB clock, asynchronous active-low reset
//   spi_mode, spiswai    00 run, 01 wait (halted when spiswai=1), 10/11 stop
//   ss                   slave select, low while a transfer is in progress
//   cpol, cpha           clock idle level, sample on leading (0) or trailing (1) edge
//   sppr, spr            prescaler / rate fields
//   BaudRateDivisor      (sppr+1) * 2^(spr+1), 2..2048
//   sclk                 serial clock
//   sample_pre/shift_pre next pclk produces a sample/shift edge on sclk
//   sample_edge/shift_edge  the above delayed one pclk, aligned with the new sclk level
module baud_rate_generator (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic [1:0]  spi_mode,
  input  logic        spiswai,
  input  logic        ss,
  input  logic        cpol,
  input  logic        cpha,
  input  logic [2:0]  sppr,
  input  logic [2:0]  spr,
  output logic [11:0] BaudRateDivisor,
  output logic        sclk,
  output logic        sample_pre,
  output logic        shift_pre,
  output logic        sample_edge,
  output logic        shift_edge
);

  logic [11:0] prescale;
  logic [3:0]  shift_amt;
  logic [11:0] half;
  logic [11:0] half_m1;
  logic [11:0] cnt;
  logic        active;
  logic        at_toggle;
  logic        leading;
  logic        next_is_sample;

  // Divisor decode: (sppr+1) << (spr+1). The shift amount needs 4 bits since spr+1 reaches 8.
  assign prescale        = {9'd0, sppr} + 12'd1;
  assign shift_amt       = {1'b0, spr} + 4'd1;
  assign BaudRateDivisor = prescale << shift_amt;

  // Half period in pclk cycles; always >= 1, so half_m1 never underflows.
  assign half    = BaudRateDivisor >> 1;
  assign half_m1 = half - 12'd1;

  // Stop mode, and wait mode with spiswai set, look exactly like a deasserted ss.
  assign active = !ss && ((spi_mode == 2'b00) || ((spi_mode == 2'b01) && !spiswai));

  assign at_toggle = active && (cnt == half_m1);

  // A toggle starting from the idle level is the leading edge. With cpha=1 the
  // sample edge is the trailing one, so XOR with cpha selects the sample edge.
  assign leading        = (sclk == cpol);
  assign next_is_sample = leading ^ cpha;

  assign sample_pre = at_toggle && next_is_sample;
  assign shift_pre  = at_toggle && !next_is_sample;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt         <= 12'd0;
      sclk        <= 1'b0;
      sample_edge <= 1'b0;
      shift_edge  <= 1'b0;
    end else begin
      // Pre-strobes are already gated by active, so the edge strobes clear
      // one pclk after the transfer stops.
      sample_edge <= sample_pre;
      shift_edge  <= shift_pre;
      if (!active) begin
        cnt  <= 12'd0;
        sclk <= cpol;
      end else if (cnt == half_m1) begin
        cnt  <= 12'd0;
        sclk <= ~sclk;
      end else begin
        // A divisor shrunk mid-run may leave cnt above half_m1; it then wraps
        // through 12 bits before matching again.
        cnt <= cnt + 12'd1;
      end
    end
  end

endmodule

// File: tb/tb_baud_rate_generator.sv
module tb_baud_rate_generator;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic [1:0]  spi_mode;
  logic        spiswai;
  logic        ss;
  logic        cpol;
  logic        cpha;
  logic [2:0]  sppr;
  logic [2:0]  spr;
  logic [11:0] BaudRateDivisor;
  logic        sclk;
  logic        sample_pre;
  logic        shift_pre;
  logic        sample_edge;
  logic        shift_edge;

  logic [4:0] obs;
  assign obs = {sclk, sample_pre, shift_pre, sample_edge, shift_edge};

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model: active-edge count since the transfer started, plus the
  // registered outputs it implies.
  int m_r   = 0;
  bit m_sclk = 1'b0;
  bit m_se   = 1'b0;
  bit m_sh   = 1'b0;

  baud_rate_generator dut (
    .pclk            (pclk),
    .preset_n        (preset_n),
    .spi_mode        (spi_mode),
    .spiswai         (spiswai),
    .ss              (ss),
    .cpol            (cpol),
    .cpha            (cpha),
    .sppr            (sppr),
    .spr             (spr),
    .BaudRateDivisor (BaudRateDivisor),
    .sclk            (sclk),
    .sample_pre      (sample_pre),
    .shift_pre       (shift_pre),
    .sample_edge     (sample_edge),
    .shift_edge      (shift_edge)
  );

  always #5 pclk = ~pclk;

  function automatic int half_of();
    return (int'(sppr) + 1) * (1 << int'(spr));
  endfunction

  function automatic bit model_active();
    return !ss && (spi_mode == 2'b00 || (spi_mode == 2'b01 && !spiswai));
  endfunction

  // Toggle number t happens at active edge t*half; odd t are leading edges.
  function automatic bit exp_pre(input bit want_sample);
    int h;
    int nxt;
    bit lead;
    h   = half_of();
    nxt = m_r + 1;
    if (!model_active() || (nxt % h) != 0) return 1'b0;
    lead = ((nxt / h) % 2) == 1;
    return (lead ^ cpha) == want_sample;
  endfunction

  function automatic logic [4:0] exp_out();
    return {m_sclk, exp_pre(1'b1), exp_pre(1'b0), m_se, m_sh};
  endfunction

  // Advance one pclk edge and update the model; returns 1 time unit after the edge.
  task automatic tick();
    bit ps;
    bit ph;
    bit act;
    ps  = exp_pre(1'b1);
    ph  = exp_pre(1'b0);
    act = model_active();
    @(posedge pclk);
    if (!preset_n) begin
      m_r = 0; m_sclk = 1'b0; m_se = 1'b0; m_sh = 1'b0;
    end else begin
      if (act) begin
        m_r++;
        m_sclk = cpol ^ (((m_r / half_of()) % 2) == 1);
      end else begin
        m_r    = 0;
        m_sclk = cpol;
      end
      m_se = ps;
      m_sh = ph;
    end
    #1;
  endtask

  task automatic test_reset();
    preset_n = 1'b0; spi_mode = 2'b00; spiswai = 1'b0; ss = 1'b1;
    cpol = 1'b1; cpha = 1'b0; sppr = 3'd0; spr = 3'd0;
    #3;
    n_checks++;
    if (obs !== 5'b00000) $display("FAIL reset_values: obs=%b exp=%b", obs, 5'b00000);
    else n_pass++;
    @(negedge pclk);
    @(negedge pclk);
    preset_n = 1'b1;
    tick();
    @(negedge pclk);
    n_checks++;
    if (obs !== 5'b10000) $display("FAIL reset_sclk_loads_cpol: obs=%b exp=%b", obs, 5'b10000);
    else n_pass++;
    cpol = 1'b0;
    tick();
    @(negedge pclk);
    n_checks++;
    if (sclk !== 1'b0) $display("FAIL idle_tracks_cpol: sclk=%b exp=0", sclk);
    else n_pass++;
  endtask

  task automatic test_divisor();
    int sp[3] = '{2, 7, 0};
    int sr[3] = '{1, 7, 0};
    int ex[3] = '{12, 2048, 2};
    int e;
    ss = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sppr = 3'(sp[i]); spr = 3'(sr[i]);
      #1;
      n_checks++;
      if (BaudRateDivisor !== 12'(ex[i]))
        $display("FAIL divisor_table[%0d]: got=%0d exp=%0d", i, BaudRateDivisor, ex[i]);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      sppr = 3'($urandom_range(0, 7)); spr = 3'($urandom_range(0, 7));
      e = (int'(sppr) + 1) * (1 << (int'(spr) + 1));
      #1;
      n_checks++;
      if (BaudRateDivisor !== 12'(e))
        $display("FAIL divisor_rand: sppr=%0d spr=%0d got=%0d exp=%0d", sppr, spr, BaudRateDivisor, e);
      else n_pass++;
    end
    sppr = 3'd0; spr = 3'd0;
    tick();
    tick();
  endtask

  task automatic test_div12();
    logic [4:0] e;
    ss = 1'b1; spi_mode = 2'b00; cpol = 1'b0; cpha = 1'b0; sppr = 3'd2; spr = 3'd1;
    tick();
    tick();
    ss = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      @(negedge pclk);
      e = exp_out();
      n_checks++;
      if (obs !== e) $display("FAIL div12_model edge=%0d: obs=%b exp=%b", k, obs, e);
      else n_pass++;
      if (k == 5) begin
        n_checks++;
        if ({sample_pre, shift_pre} !== 2'b10) $display("FAIL div12_sample_pre: got=%b exp=10", {sample_pre, shift_pre});
        else n_pass++;
      end
      if (k == 6) begin
        n_checks++;
        if ({sclk, sample_edge} !== 2'b11) $display("FAIL div12_rise: got=%b exp=11", {sclk, sample_edge});
        else n_pass++;
      end
      if (k == 12) begin
        n_checks++;
        if ({sclk, shift_edge} !== 2'b01) $display("FAIL div12_fall: got=%b exp=01", {sclk, shift_edge});
        else n_pass++;
      end
    end
    ss = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_cpol1_cpha1();
    logic [4:0] e;
    ss = 1'b1; cpol = 1'b1; cpha = 1'b1; sppr = 3'd1; spr = 3'd0;
    tick();
    tick();
    @(negedge pclk);
    n_checks++;
    if (sclk !== 1'b1) $display("FAIL cpol1_idle: sclk=%b exp=1", sclk);
    else n_pass++;
    ss = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      @(negedge pclk);
      e = exp_out();
      n_checks++;
      if (obs !== e) $display("FAIL cpha1_model edge=%0d: obs=%b exp=%b", k, obs, e);
      else n_pass++;
      if (k == 2) begin
        n_checks++;
        if ({sclk, shift_edge, sample_edge} !== 3'b010) $display("FAIL cpha1_first_shift: got=%b exp=010", {sclk, shift_edge, sample_edge});
        else n_pass++;
      end
      if (k == 4) begin
        n_checks++;
        if ({sclk, shift_edge, sample_edge} !== 3'b101) $display("FAIL cpha1_first_sample: got=%b exp=101", {sclk, shift_edge, sample_edge});
        else n_pass++;
      end
    end
    ss = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_div2();
    logic [4:0] e;
    bit prev_sclk;
    bit prev_sp;
    ss = 1'b1; cpol = 1'b0; cpha = 1'b0; sppr = 3'd0; spr = 3'd0;
    tick();
    ss = 1'b0;
    @(negedge pclk);
    prev_sclk = sclk;
    prev_sp   = sample_pre;
    for (int k = 1; k <= 12; k++) begin
      tick();
      @(negedge pclk);
      e = exp_out();
      n_checks++;
      if (obs !== e) $display("FAIL div2_model edge=%0d: obs=%b exp=%b", k, obs, e);
      else n_pass++;
      n_checks++;
      if ((sample_pre ^ shift_pre) !== 1'b1 || sample_pre === prev_sp || sclk === prev_sclk)
        $display("FAIL div2_alternate edge=%0d: sclk=%b pre=%b%b", k, sclk, sample_pre, shift_pre);
      else n_pass++;
      prev_sclk = sclk;
      prev_sp   = sample_pre;
    end
    ss = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_ss_abort();
    logic [4:0] e;
    int first;
    ss = 1'b1; cpol = 1'b0; cpha = 1'b0; sppr = 3'd2; spr = 3'd1;
    tick();
    ss = 1'b0;
    // Abort in the high phase with cnt=3 (toggle at edge 6, edge 9 leaves cnt=3).
    for (int k = 1; k <= 9; k++) tick();
    ss = 1'b1;
    @(negedge pclk);
    n_checks++;
    if ({sclk, sample_pre, shift_pre} !== 3'b100) $display("FAIL abort_before: got=%b exp=100", {sclk, sample_pre, shift_pre});
    else n_pass++;
    tick();
    @(negedge pclk);
    n_checks++;
    if ({sclk, sample_pre, shift_pre} !== 3'b000) $display("FAIL abort_return_cpol: got=%b exp=000", {sclk, sample_pre, shift_pre});
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge pclk);
      n_checks++;
      if (obs !== 5'b00000) $display("FAIL abort_quiet k=%0d: obs=%b exp=00000", k, obs);
      else n_pass++;
    end
    ss = 1'b0;
    first = -1;
    for (int k = 1; k <= 20 && first < 0; k++) begin
      tick();
      @(negedge pclk);
      e = exp_out();
      n_checks++;
      if (obs !== e) $display("FAIL abort_restart_model edge=%0d: obs=%b exp=%b", k, obs, e);
      else n_pass++;
      if (sclk === 1'b1) first = k;
    end
    n_checks++;
    if (first != 6) $display("FAIL abort_restart_first_toggle: edge=%0d exp=6", first);
    else n_pass++;
    ss = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_wait_mode();
    logic [4:0] e;
    int toggles;
    bit prev;
    ss = 1'b1; cpol = 1'b1; cpha = 1'b0; sppr = 3'd1; spr = 3'd0;
    spi_mode = 2'b01; spiswai = 1'b1;
    tick();
    ss = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge pclk);
      n_checks++;
      if (obs !== 5'b10000) $display("FAIL wait_halted k=%0d: obs=%b exp=10000", k, obs);
      else n_pass++;
    end
    spiswai = 1'b0;
    toggles = 0;
    prev = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      @(negedge pclk);
      e = exp_out();
      n_checks++;
      if (obs !== e) $display("FAIL wait_running edge=%0d: obs=%b exp=%b", k, obs, e);
      else n_pass++;
      if (sclk !== prev) toggles++;
      prev = sclk;
    end
    n_checks++;
    if (toggles != 5) $display("FAIL wait_toggle_count: got=%0d exp=5", toggles);
    else n_pass++;
    for (int m = 2; m <= 3; m++) begin
      spi_mode = 2'(m);
      tick();
      for (int k = 0; k < 5; k++) begin
        tick();
        @(negedge pclk);
        n_checks++;
        if (obs !== 5'b10000) $display("FAIL stop_mode%0d k=%0d: obs=%b exp=10000", m, k, obs);
        else n_pass++;
      end
    end
    spi_mode = 2'b00;
    ss = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    ss = 1'b1; cpol = 1'b0; cpha = 1'b0; sppr = 3'd1; spr = 3'd0;
    tick();
    ss = 1'b0;
    tick();
    tick();
    tick();
    @(negedge pclk);
    n_checks++;
    if (sclk !== 1'b1) $display("FAIL areset_setup: sclk=%b exp=1", sclk);
    else n_pass++;
    #2;
    preset_n = 1'b0;
    #1;
    n_checks++;
    if ({sclk, sample_edge, shift_edge} !== 3'b000) $display("FAIL areset_immediate: got=%b exp=000", {sclk, sample_edge, shift_edge});
    else n_pass++;
    m_r = 0; m_sclk = 1'b0; m_se = 1'b0; m_sh = 1'b0;
    ss = 1'b1;
    @(negedge pclk);
    preset_n = 1'b1;
    cpol = 1'b1;
    tick();
    @(negedge pclk);
    n_checks++;
    if (obs !== 5'b10000) $display("FAIL areset_recover: obs=%b exp=10000", obs);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0] e;
    for (int ep = 0; ep < 6; ep++) begin
      ss = 1'b1; spi_mode = 2'b00; spiswai = 1'b0;
      sppr = 3'($urandom_range(0, 3)); spr = 3'($urandom_range(0, 2));
      cpol = 1'($urandom_range(0, 1)); cpha = 1'($urandom_range(0, 1));
      tick();
      tick();
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 99) < 6)  ss = ~ss;
        if ($urandom_range(0, 99) < 3)  spi_mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 99) < 3)  spiswai = ~spiswai;
        if (!model_active() && $urandom_range(0, 99) < 20) begin
          sppr = 3'($urandom_range(0, 3)); spr = 3'($urandom_range(0, 2));
          cpol = 1'($urandom_range(0, 1)); cpha = 1'($urandom_range(0, 1));
        end
        @(negedge pclk);
        e = exp_out();
        n_checks++;
        if (obs !== e) $display("FAIL random ep=%0d cyc=%0d: obs=%b exp=%b", ep, c, obs, e);
        else n_pass++;
        tick();
      end
    end
    ss = 1'b1; spi_mode = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_divisor();
    test_div12();
    test_cpol1_cpha1();
    test_div2();
    test_ss_abort();
    test_wait_mode();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/baud_rate_generator.md
# baud_rate_generator

Generates the SPI serial clock and the per-edge strobes for one master-mode SPI controller, clocked by the APB clock. It decodes the prescaler fields into the 12-bit `BaudRateDivisor` consumed by the slave-select stage. It runs only while a transfer is in progress (`ss` low), and it supplies sample and shift strobes to the downstream shift register.

## Interface
Parameters: none; all widths are fixed.

- `pclk` in 1: APB clock; all state is on its rising edge.
- `preset_n` in 1: asynchronous, active-low reset.
- `spi_mode` in 2: 00 run, 01 wait, 10/11 stop.
- `spiswai` in 1: SPI stop-in-wait; halts the generator when `spi_mode`=01.
- `ss` in 1: slave select from the slave-select stage; low means a transfer is active.
- `cpol` in 1: clock idle level.
- `cpha` in 1: 0 samples on the leading edge, 1 samples on the trailing edge.
- `sppr` in 3: prescaler selection.
- `spr` in 3: rate selection.
- `BaudRateDivisor` out 12: (sppr+1) * 2^(spr+1), combinational.
- `sclk` out 1: serial clock, registered.
- `sample_pre` out 1: the next `sclk` edge is a sample edge and occurs at the next `pclk`, combinational.
- `shift_pre` out 1: the next `sclk` edge is a shift edge and occurs at the next `pclk`, combinational.
- `sample_edge` out 1: `sample_pre` delayed by one `pclk`, so it coincides with the new `sclk` value. Registered.
- `shift_edge` out 1: `shift_pre` delayed by one `pclk`. Registered.

## Operation
- Divisor range: 2 (sppr=0, spr=0) to 2048 (sppr=7, spr=7), so it always fits in 12 bits.
- half = `BaudRateDivisor`>>1, range 1..1024.
- active = !`ss` && (`spi_mode`==00 || (`spi_mode`==01 && !`spiswai`)).
- 12-bit counter `cnt`:
  - when active and `cnt`==half-1: `sclk` toggles and `cnt` goes to 0;
  - otherwise when active: `cnt` increments by 1;
  - when not active: `cnt` goes to 0 and `sclk` loads `cpol`.
- Leading edge: a toggle while `sclk`==`cpol`. Trailing edge: a toggle while `sclk`!=`cpol`.
- Sample edge is the leading edge when `cpha`=0 and the trailing edge when `cpha`=1. Shift edge is the other one.
- `sample_pre` = active && `cnt`==half-1 && the pending toggle is a sample edge. `shift_pre` is defined the same way for the shift edge. The two are never high together.
- `sample_edge` and `shift_edge` are one-cycle pulses. Each is cleared on the next `pclk` after active drops.
- No state machine beyond the counter and the `sclk` phase: IDLE (not active) and RUN (active).

## Timing
- Reset values: `sclk`=0, `cnt`=0, `sample_edge`=0, `shift_edge`=0. `sclk` loads `cpol` on the first `pclk` after reset while idle.
- First toggle: `ss` sampled low at edge k. RUN begins with `cnt`=0, and the first toggle (a leading edge) happens at edge k+half.
- `sclk` period = `BaudRateDivisor` pclk cycles, 50% duty cycle.
- Divisor 2 (half=1): `cnt` stays 0, `sclk` toggles every `pclk`, and exactly one pre-strobe is high every cycle, alternating between sample and shift.
- `ss` rises mid-transfer:
  - at the next `pclk`, `cnt`=0, `sclk`=`cpol`, and the pre-strobes are 0;
  - the edge strobes are 0 one `pclk` later;
  - a partial `sclk` phase is truncated with no glitch beyond the return to `cpol`.
- Wait mode with `spiswai`=1: behaves as `ss` high. Resuming restarts from `cnt`=0.
- `cpol` or `cpha` changes during RUN are illegal. During IDLE, `sclk` tracks `cpol` with one cycle of latency.
- `sppr` or `spr` changes during RUN take effect on the next comparison. If the new half-1 is below the current `cnt`, the counter increments until 12-bit wrap and then matches.
- Asynchronous reset mid-transfer forces the reset values immediately.

## Test plan
- Divisor decode: sppr=2, spr=1 -> `BaudRateDivisor`=12. sppr=7, spr=7 -> 2048. sppr=0, spr=0 -> 2.
- Divisor 12, `cpol`=0, `cpha`=0, `ss` low at edge 0:
  - `sclk` rises at edge 6 and falls at edge 12, with period 12;
  - `sample_pre` is high in the cycle before edge 6;
  - `sample_edge` is high in the cycle after edge 6;
  - the shift strobes do the same around edge 12.
- `cpol`=1, `cpha`=1, divisor 4: idle `sclk`=1; first toggle to 0 at edge 2 raises `shift_edge`; toggle to 1 at edge 4 raises `sample_edge`.
- Divisor 2: `sclk` toggles every `pclk`, and `sample_pre`/`shift_pre` alternate every cycle with no gaps.
- `ss` rises at `cnt`=3 of half 6: `sclk` returns to `cpol` at the next edge, and no strobe fires afterwards. `ss` falls again: the first toggle occurs half cycles later.
- `spi_mode`=01 with `spiswai`=1 -> `sclk` held at `cpol` and strobes 0. `spiswai`=0 -> normal toggling. `spi_mode`=10 -> idle regardless of `ss`. Reset asserted mid-RUN -> `sclk`=0 immediately.
